combo_code_sender: RTL and testbench

//  Initiator side of the combo-lock code interface: sends a stored multi-digit

---
 rtl/combo_code_sender_if.sv | 42 ++++
 rtl/combo_code_sender.sv | 206 ++++++++++++++++++++
 tb/tb_combo_code_sender.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/combo_code_sender_if.sv
// Code-interface bundle between the combo sender and its environment.
// COMBO_SENDER_RETRY_EN adds the retried indication.
interface combo_code_sender_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   combo;
    logic [3:0]            code_out;
    logic                  lock_rst;
    logic                  unlock_in;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  fail;
`ifdef COMBO_SENDER_RETRY_EN
    logic                  retried;
`endif
    logic [2:0]            state_dbg;

    // start is a single-cycle request, honoured only while the sender is idle
    // (busy=0); there is no ready signal. done/pass/fail (and retried) are
    // qualified by done, and pass/fail hold until the next accepted start.
`ifdef COMBO_SENDER_RETRY_EN
    modport master (
        input  start, combo, unlock_in,
        output code_out, lock_rst, busy, done, pass, fail, retried, state_dbg
    );
    modport slave (
        output start, combo, unlock_in,
        input  code_out, lock_rst, busy, done, pass, fail, retried, state_dbg
    );
`else
    modport master (
        input  start, combo, unlock_in,
        output code_out, lock_rst, busy, done, pass, fail, state_dbg
    );
    modport slave (
        output start, combo, unlock_in,
        input  code_out, lock_rst, busy, done, pass, fail, state_dbg
    );
`endif
endinterface

// File: rtl/combo_code_sender.sv
// Sends a latched nibble combination into a lock, then reports pass/fail from unlock_in.
// Optional feature macro: COMBO_SENDER_RETRY_EN (one automatic retry after a timeout).
module combo_code_sender #(
    parameter int DIGITS      = 4,
    parameter int HOLD_CYC    = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    combo_code_sender_if.master   bus
);
    localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_HG > TIMEOUT_CYC) ? MAX_HG : TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = $clog2(DIGITS + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DRIVE = 3'd2,
        GAP   = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [4*DIGITS-1:0]  combo_q, combo_n;
    logic [3:0]           code_q, code_n;
    logic                 lock_rst_q, lock_rst_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 pass_q, pass_n;
    logic                 fail_q, fail_n;
    logic [3:0]           cur_digit;
    logic [3:0]           next_digit;
`ifdef COMBO_SENDER_RETRY_EN
    logic                 retry_q, retry_n;
`endif

    assign cur_digit = combo_q[{idx, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            combo_q    <= '0;
            code_q     <= 4'h0;
            lock_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
`ifdef COMBO_SENDER_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            combo_q    <= combo_n;
            code_q     <= code_n;
            lock_rst_q <= lock_rst_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            pass_q     <= pass_n;
            fail_q     <= fail_n;
`ifdef COMBO_SENDER_RETRY_EN
            retry_q    <= retry_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        combo_n    = combo_q;
        pass_n     = pass_q;
        fail_n     = fail_q;
        code_n     = 4'h0;
        lock_rst_n = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        next_digit = 4'h0;
`ifdef COMBO_SENDER_RETRY_EN
        retry_n    = retry_q;
`endif

        case (state)
            IDLE: begin
                if (bus.start) begin
                    combo_n = bus.combo;
                    pass_n  = 1'b0;
                    fail_n  = 1'b0;
`ifdef COMBO_SENDER_RETRY_EN
                    retry_n = 1'b0;
`endif
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                idx_n   = '0;
                cnt_n   = '0;
                state_n = DRIVE;
            end
            DRIVE: begin
                // 0 is the idle/gap value, so a zero digit aborts the sequence
                if (cur_digit == 4'h0) begin
                    fail_n  = 1'b1;
                    state_n = DONE;
                end else if (cnt == HOLD_LAST) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (idx == IDX_LAST) begin
                        state_n = WAIT;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = DRIVE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (bus.unlock_in) begin
                    cnt_n   = '0;
                    pass_n  = 1'b1;
                    state_n = DONE;
                end else if (cnt == TO_LAST) begin
                    cnt_n = '0;
`ifdef COMBO_SENDER_RETRY_EN
                    if (!retry_q) begin
                        retry_n = 1'b1;
                        state_n = CLEAR;
                    end else begin
                        fail_n  = 1'b1;
                        state_n = DONE;
                    end
`else
                    fail_n  = 1'b1;
                    state_n = DONE;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered from the state being entered, so they line up with it.
        next_digit = combo_n[{idx_n, 2'b00} +: 4];
        case (state_n)
            CLEAR: begin
                lock_rst_n = 1'b1;
                busy_n     = 1'b1;
            end
            DRIVE: begin
                code_n = next_digit;
                busy_n = 1'b1;
            end
            GAP, WAIT: begin
                busy_n = 1'b1;
            end
            DONE: begin
                busy_n = 1'b1;
                done_n = 1'b1;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    assign bus.code_out  = code_q;
    assign bus.lock_rst  = lock_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.state_dbg = state;
`ifdef COMBO_SENDER_RETRY_EN
    assign bus.retried   = retry_q;
`endif

endmodule

// File: tb/tb_combo_code_sender.sv
// Bench for combo_code_sender: cycle-trace model, summary table, reset and random runs.
// Follows COMBO_SENDER_RETRY_EN when the design is built with it.
module tb_combo_code_sender;
  localparam int DIGITS = 4;
  localparam int HOLD   = 4;
  localparam int GAPC   = 2;
  localparam int TO     = 16;
`ifdef COMBO_SENDER_RETRY_EN
  localparam bit RETRY  = 1'b1;
`else
  localparam bit RETRY  = 1'b0;
`endif
  localparam int OW = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   seq_no;

  logic [OW-1:0] exp_q[$];
  logic [1:0]    drv_q[$];

  combo_code_sender_if #(.DIGITS(DIGITS)) bus ();

  combo_code_sender #(
    .DIGITS(DIGITS), .HOLD_CYC(HOLD), .GAP_CYC(GAPC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] outs();
    logic r;
`ifdef COMBO_SENDER_RETRY_EN
    r = bus.retried;
`else
    r = 1'b0;
`endif
    return {r, bus.code_out, bus.lock_rst, bus.busy, bus.done, bus.pass, bus.fail};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference model: one record per cycle after the accepting edge
  function automatic void push(input logic [3:0] code, input bit lrst, input bit busy,
                               input bit done, input bit p, input bit f, input bit r,
                               input bit st, input bit un);
    exp_q.push_back({r, code, lrst, busy, done, p, f});
    drv_q.push_back({st, un});
  endfunction

  function automatic bit rnd_bit(input bit en);
    return en ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void build(input logic [15:0] cmb, input int k0, input int k1,
                                input bit noise);
    bit retried_f = 1'b0;
    bit pass_f    = 1'b0;
    bit fail_f    = 1'b0;
    bit finished  = 1'b0;
    exp_q.delete();
    drv_q.delete();
    for (int att = 0; att < 2 && !finished; att++) begin
      int k = (att == 0) ? k0 : k1;
      bit illegal = 1'b0;
      push(4'h0, 1, 1, 0, 0, 0, retried_f, noise, rnd_bit(noise));
      for (int d = 0; d < DIGITS && !illegal; d++) begin
        logic [3:0] nib = cmb[4*d +: 4];
        if (nib == 4'h0) begin
          push(4'h0, 0, 1, 0, 0, 0, retried_f, noise, rnd_bit(noise));
          illegal  = 1'b1;
          fail_f   = 1'b1;
          finished = 1'b1;
        end else begin
          for (int h = 0; h < HOLD; h++) push(nib, 0, 1, 0, 0, 0, retried_f, noise, rnd_bit(noise));
          for (int g = 0; g < GAPC; g++) push(4'h0, 0, 1, 0, 0, 0, retried_f, noise, rnd_bit(noise));
        end
      end
      if (!illegal) begin
        bit seen = 1'b0;
        for (int c = 0; c < TO && !seen; c++) begin
          seen = (c == k);
          push(4'h0, 0, 1, 0, 0, 0, retried_f, noise, seen);
        end
        if (seen) begin
          pass_f   = 1'b1;
          finished = 1'b1;
        end else if (RETRY && att == 0) begin
          retried_f = 1'b1;
        end else begin
          fail_f   = 1'b1;
          finished = 1'b1;
        end
      end
    end
    push(4'h0, 0, 1, 1, pass_f, fail_f, retried_f, noise, 1'b0);
    push(4'h0, 0, 0, 0, pass_f, fail_f, retried_f, 1'b0, 1'b0);
  endfunction

  // driver: accept start, then walk the expected trace cycle by cycle
  task automatic run_seq(input logic [15:0] cmb, input int k0, input int k1, input bit noise,
                         output int done_at, output logic p, output logic f);
    logic [OW-1:0] e;
    logic [1:0]    d;
    build(cmb, k0, k1, noise);
    seq_no++;
    done_at = -1;
    bus.start     = 1'b1;
    bus.combo     = cmb;
    bus.unlock_in = 1'b0;
    step();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      d = drv_q.pop_front();
      chk($sformatf("trace seq%0d rec%0d", seq_no, i), 32'(outs()), 32'(e));
      if (bus.done && done_at < 0) done_at = i;
      bus.start     = d[1];
      bus.unlock_in = d[0];
      if (noise) bus.combo = 16'($urandom);
      step();
    end
    p = bus.pass;
    f = bus.fail;
  endtask

  typedef struct {
    logic [15:0] combo;
    int          k0;
    int          k1;
    bit          noise;
    int          exp_done;
    bit          exp_pass;
    bit          exp_fail;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int   done_at;
    logic p;
    logic f;

    tbl[0] = '{16'h4321,  3, -1, 1'b0, 29, 1'b1, 1'b0};
    tbl[1] = '{16'h4321, -1, -1, 1'b0, RETRY ? 82 : 41, 1'b0, 1'b1};
    tbl[2] = '{16'h4021,  3,  3, 1'b0, 14, 1'b0, 1'b1};
    tbl[3] = '{16'h4321,  0,  0, 1'b1, 26, 1'b1, 1'b0};
    tbl[4] = '{16'h9F5A, 15, -1, 1'b0, 41, 1'b1, 1'b0};
    tbl[5] = '{16'h1230,  0,  0, 1'b0,  2, 1'b0, 1'b1};
    tbl[6] = '{16'h4321, -1,  5, 1'b0, RETRY ? 72 : 41, RETRY, !RETRY};

    n_checks = 0;
    n_fail   = 0;
    seq_no   = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.combo     = '0;
    bus.unlock_in = 1'b0;
    repeat (3) step();
    chk("reset outs", 32'(outs()), 32'h0);
    chk("reset state", 32'(bus.state_dbg), 32'h0);
    rst = 1'b0;
    step();
    chk("idle after reset", 32'(outs()), 32'h0);

    for (int t = 0; t < 7; t++) begin
      run_seq(tbl[t].combo, tbl[t].k0, tbl[t].k1, tbl[t].noise, done_at, p, f);
      chk($sformatf("tbl%0d done_at", t), 32'(done_at), 32'(tbl[t].exp_done));
      chk($sformatf("tbl%0d pass", t), 32'(p), 32'(tbl[t].exp_pass));
      chk($sformatf("tbl%0d fail", t), 32'(f), 32'(tbl[t].exp_fail));
    end

    // reset while the third digit is on code_out
    bus.start = 1'b1;
    bus.combo = 16'h4321;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    chk("mid code before rst", 32'(bus.code_out), 32'h3);
    chk("mid busy before rst", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst outs", 32'(outs()), 32'h0);
    step();
    #2 rst = 1'b0;
    step();
    chk("after rst outs", 32'(outs()), 32'h0);
    chk("after rst state", 32'(bus.state_dbg), 32'h0);
    run_seq(16'h8765, 2, 2, 1'b0, done_at, p, f);
    chk("post rst done_at", 32'(done_at), 32'd28);
    chk("post rst pass", 32'(p), 32'h1);

    // random sequences against the model
    for (int r = 0; r < 24; r++) begin
      logic [15:0] cmb;
      for (int d = 0; d < DIGITS; d++)
        cmb[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_seq(cmb, $urandom_range(0, 20), $urandom_range(0, 20), 1'($urandom_range(0, 1)),
              done_at, p, f);
      chk($sformatf("rnd%0d outcome", r), 32'(p ^ f), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
